// File: rtl/frame_scheduler.sv
// Frame-rate sequencer: launches one led_driver refresh per frame period and arbitrates buffer ownership with the host.
// Latency: commit ack/err one cycle after strobe; ctrl_update rises one cycle after frame_tick, falls one cycle after done.
// Backpressure: a slow led_driver stalls in UPDATE; ticks arriving then are skipped. Optional FRAME_SCHED_STATS_EN adds event counters.
module frame_scheduler #(
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_BUFS     = 2,
  parameter int FRAME_PERIOD = 1000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  host_commit,
  input  logic [DATA_WIDTH-1:0] host_commit_id,
  output logic                  host_commit_ack,
  output logic                  host_commit_err,
  output logic [DATA_WIDTH-1:0] disp_buf_id,
  output logic                  pending_valid,
  output logic                  frame_tick,
  output logic                  ctrl_update,
  output logic [DATA_WIDTH-1:0] ctrl_buf_id,
  input  logic                  ctrl_update_done
`ifdef FRAME_SCHED_STATS_EN
  ,
  output logic [31:0]           stat_frames,
  output logic [15:0]           stat_overruns,
  output logic [15:0]           stat_drops
`endif
);

  localparam int CW = (FRAME_PERIOD > 1) ? $clog2(FRAME_PERIOD) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_PERIOD - 1);

  typedef enum logic [1:0] {
    S_WAIT    = 2'd0,
    S_UPDATE  = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t                state;
  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] pending_id;

  logic                  id_in_range;
  logic                  commit_ok;
  logic                  commit_err;
  logic                  launch;
  logic                  overrun;
  logic                  drop;
  logic [DATA_WIDTH-1:0] next_disp;

  // Frame period counter: free-runs 0..FRAME_PERIOD-1 while enabled, parked at 0 otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (!enable || cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign frame_tick = enable && (cnt == CNT_LAST);

  // Commit legality and frame-launch decisions; a commit landing on a launching tick bypasses the pending slot.
  always_comb begin
    id_in_range = host_commit_id < DATA_WIDTH'(NUM_BUFS);
    commit_ok   = host_commit && id_in_range && (host_commit_id != disp_buf_id);
    commit_err  = host_commit && !commit_ok;
    launch      = frame_tick && (state == S_WAIT);
    overrun     = frame_tick && (state != S_WAIT);
    drop        = commit_ok && pending_valid;
    next_disp   = disp_buf_id;
    if (commit_ok) begin
      next_disp = host_commit_id;
    end else if (pending_valid) begin
      next_disp = pending_id;
    end
  end

  // Update handshake FSM plus buffer ownership; all outputs registered here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= S_WAIT;
      ctrl_update     <= 1'b0;
      ctrl_buf_id     <= '0;
      disp_buf_id     <= '0;
      pending_id      <= '0;
      pending_valid   <= 1'b0;
      host_commit_ack <= 1'b0;
      host_commit_err <= 1'b0;
    end else begin
      host_commit_ack <= commit_ok;
      host_commit_err <= commit_err;

      if (launch) begin
        // The pending entry is either consumed or superseded by a same-cycle commit.
        disp_buf_id   <= next_disp;
        ctrl_buf_id   <= next_disp;
        pending_valid <= 1'b0;
      end else if (commit_ok) begin
        pending_id    <= host_commit_id;
        pending_valid <= 1'b1;
      end

      case (state)
        S_WAIT: begin
          if (launch) begin
            state       <= S_UPDATE;
            ctrl_update <= 1'b1;
          end
        end
        S_UPDATE: begin
          if (ctrl_update_done) begin
            state       <= S_RELEASE;
            ctrl_update <= 1'b0;
          end
        end
        S_RELEASE: begin
          state <= S_WAIT;
        end
        default: begin
          state       <= S_WAIT;
          ctrl_update <= 1'b0;
        end
      endcase
    end
  end

`ifdef FRAME_SCHED_STATS_EN
  // Saturating event counters: launched frames, skipped ticks, replaced pending buffers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_frames   <= '0;
      stat_overruns <= '0;
      stat_drops    <= '0;
    end else begin
      if (launch && stat_frames != '1) begin
        stat_frames <= stat_frames + 1'b1;
      end
      if (overrun && stat_overruns != '1) begin
        stat_overruns <= stat_overruns + 1'b1;
      end
      if (drop && stat_drops != '1) begin
        stat_drops <= stat_drops + 1'b1;
      end
    end
  end
`else
  logic unused_drop_overrun;
  assign unused_drop_overrun = drop ^ overrun;
`endif

endmodule

// File: tb/tb_frame_scheduler.sv
// Bench for frame_scheduler with NUM_BUFS=3, FRAME_PERIOD=50 and a behavioural led_driver.
// Expected refreshes and commit responses are queued by the stimulus and popped by a monitor.
// Cycle numbers count rising edges since reset release.
module tb_frame_scheduler;

  localparam int DW = 32;
  localparam int NB = 3;
  localparam int FP = 50;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          host_commit;
  logic [DW-1:0] host_commit_id;
  logic          host_commit_ack;
  logic          host_commit_err;
  logic [DW-1:0] disp_buf_id;
  logic          pending_valid;
  logic          frame_tick;
  logic          ctrl_update;
  logic [DW-1:0] ctrl_buf_id;
  logic          ctrl_update_done;
`ifdef FRAME_SCHED_STATS_EN
  logic [31:0]   stat_frames;
  logic [15:0]   stat_overruns;
  logic [15:0]   stat_drops;
`endif

  frame_scheduler #(
    .DATA_WIDTH  (DW),
    .NUM_BUFS    (NB),
    .FRAME_PERIOD(FP)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .enable          (enable),
    .host_commit     (host_commit),
    .host_commit_id  (host_commit_id),
    .host_commit_ack (host_commit_ack),
    .host_commit_err (host_commit_err),
    .disp_buf_id     (disp_buf_id),
    .pending_valid   (pending_valid),
    .frame_tick      (frame_tick),
    .ctrl_update     (ctrl_update),
    .ctrl_buf_id     (ctrl_buf_id),
    .ctrl_update_done(ctrl_update_done)
`ifdef FRAME_SCHED_STATS_EN
    ,
    .stat_frames     (stat_frames),
    .stat_overruns   (stat_overruns),
    .stat_drops      (stat_drops)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int id;
    int at;
  } upd_t;

  upd_t exp_upd[$];
  bit   exp_cmt[$];

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int drv_delay = 10;
  int ticks_on = 0;
  int ticks_off = 0;

  always @(posedge clk) if (reset) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic commit(input int id, input bit ack);
    exp_cmt.push_back(ack);
    host_commit    = 1'b1;
    host_commit_id = DW'(id);
    @(negedge clk);
    host_commit    = 1'b0;
    host_commit_id = '0;
  endtask

  // Monitor: pops one expectation per refresh rising edge and per commit response.
  initial begin
    logic prev_upd;
    upd_t e;
    bit   ea;
    prev_upd = 1'b0;
    forever begin
      @(negedge clk);
      if (frame_tick) begin
        if (enable) ticks_on++;
        else ticks_off++;
      end
      if (ctrl_update && !prev_upd) begin
        if (exp_upd.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_update: got id %0d at cycle %0d, required none", ctrl_buf_id, cyc);
        end else begin
          e = exp_upd.pop_front();
          chk("update_cycle", cyc, e.at);
          chk("update_buf_id", ctrl_buf_id, e.id);
          chk("update_disp_id", disp_buf_id, e.id);
        end
      end
      prev_upd = ctrl_update;
      if (host_commit_ack || host_commit_err) begin
        if (exp_cmt.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_commit_resp: got ack=%0b err=%0b at cycle %0d, required none",
                   host_commit_ack, host_commit_err, cyc);
        end else begin
          ea = exp_cmt.pop_front();
          chk("commit_ack", host_commit_ack, ea);
          chk("commit_err", host_commit_err, !ea);
        end
      end
    end
  end

  // Behavioural led_driver: pulses done drv_delay cycles after each request.
  initial begin
    ctrl_update_done = 1'b0;
    forever begin
      @(negedge clk);
      if (ctrl_update) begin
        repeat (drv_delay - 1) @(negedge clk);
        ctrl_update_done = 1'b1;
        @(negedge clk);
        ctrl_update_done = 1'b0;
        while (ctrl_update) @(negedge clk);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test by 100000 ns, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset          = 1'b0;
    enable         = 1'b0;
    host_commit    = 1'b0;
    host_commit_id = '0;
    repeat (3) @(negedge clk);

    chk("rst_ctrl_update", ctrl_update, 0);
    chk("rst_ctrl_buf_id", ctrl_buf_id, 0);
    chk("rst_disp_buf_id", disp_buf_id, 0);
    chk("rst_pending_valid", pending_valid, 0);
    chk("rst_frame_tick", frame_tick, 0);
    chk("rst_commit_ack", host_commit_ack, 0);
    chk("rst_commit_err", host_commit_err, 0);

    // Free-running refresh of buffer 0, then a mid-frame commit of buffer 1.
    exp_upd.push_back('{0, 50});
    exp_upd.push_back('{0, 100});
    exp_upd.push_back('{1, 150});
    reset  = 1'b1;
    enable = 1'b1;

    wait_cyc(120);
    commit(1, 1'b1);
    chk("pending_after_commit", pending_valid, 1);
    wait_cyc(151);
    chk("pending_after_swap", pending_valid, 0);
    chk("disp_after_swap", disp_buf_id, 1);

    // Rejections: displayed id, far out of range, first out-of-range id.
    exp_upd.push_back('{1, 200});
    wait_cyc(170);
    commit(1, 1'b0);
    commit(5, 1'b0);
    commit(3, 1'b0);
    chk("pending_after_rejects", pending_valid, 0);

    // Show buffer 2, then two commits in one frame: the later one wins.
    wait_cyc(210);
    commit(2, 1'b1);
    exp_upd.push_back('{2, 250});
    wait_cyc(260);
    commit(0, 1'b1);
    wait_cyc(262);
    commit(1, 1'b1);
    chk("pending_after_replace", pending_valid, 1);
`ifdef FRAME_SCHED_STATS_EN
    chk("stat_drops", stat_drops, 1);
`endif
    exp_upd.push_back('{1, 300});

    // Slow led_driver spanning two ticks.
    wait_cyc(280);
    drv_delay = 120;
    exp_upd.push_back('{1, 450});
    wait_cyc(430);
    drv_delay = 20;
`ifdef FRAME_SCHED_STATS_EN
    chk("stat_overruns", stat_overruns, 2);
    chk("stat_frames_mid", stat_frames, 6);
`endif

    // Commit in the tick cycle, then drop enable during the update.
    exp_upd.push_back('{0, 500});
    wait_cyc(499);
    commit(0, 1'b1);
    wait_cyc(505);
    enable = 1'b0;
    wait_cyc(700);
    chk("idle_ctrl_update", ctrl_update, 0);
    chk("idle_pending", pending_valid, 0);
    chk("idle_disp", disp_buf_id, 0);
    chk("ticks_enabled", ticks_on, 10);
    chk("ticks_disabled", ticks_off, 0);
`ifdef FRAME_SCHED_STATS_EN
    chk("stat_frames_end", stat_frames, 8);
`endif

    // Re-enable; counter restarts from 0. Then reset mid-update.
    drv_delay = 30;
    enable    = 1'b1;
    exp_upd.push_back('{0, 750});
    wait_cyc(760);
    chk("pre_reset_ctrl_update", ctrl_update, 1);
    reset = 1'b0;
    #1;
    chk("reset_ctrl_update", ctrl_update, 0);
    chk("reset_ctrl_buf_id", ctrl_buf_id, 0);
    chk("reset_disp", disp_buf_id, 0);
`ifdef FRAME_SCHED_STATS_EN
    chk("reset_stat_frames", stat_frames, 0);
`endif

    chk("updates_left", exp_upd.size(), 0);
    chk("commits_left", exp_cmt.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
